// File: rtl/mux_nto1_reg.sv
// rtl/mux_nto1_reg.sv - N-to-1 stream mux with registered output, select or round-robin grant
// Optional round-robin arbitration is compiled in with `define MUX_NTO1_REG_RR_EN;
// without it the mode port is ignored and the block always works in select mode.
module mux_nto1_reg #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    localparam int SW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SW-1:0]      sel,
    input  logic               mode,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    output logic [SW-1:0]      out_chan,
    input  logic               out_ready
);

    // Channel count widened by one bit so sel can be compared against N for any N.
    localparam logic [SW:0] N_L = (SW+1)'(N);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    out_chan_q, out_chan_d;

    logic             load;
    logic             sel_ok;
    logic             grant_valid;
    logic [SW-1:0]    grant;
    logic [WIDTH-1:0] grant_data;
    logic             grant_in_valid;
    logic             xfer;

    assign sel_ok = ({1'b0, sel} < N_L);

`ifdef MUX_NTO1_REG_RR_EN
    // ptr remembers the last round-robin winner; the search starts just after it.
    logic [SW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] rr_grant;
    logic [SW-1:0] rr_cand;
    logic          rr_found;

    // Round-robin search: first valid channel at ptr+1, ptr+2, ... modulo N.
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_cand  = '0;
        for (int k = 1; k <= N; k++) begin
            rr_cand = SW'((int'(ptr_q) + k) % N);
            if (!rr_found && in_valid[rr_cand]) begin
                rr_found = 1'b1;
                rr_grant = rr_cand;
            end
        end
    end

    // Grant source: mode is taken live, so a switch applies in the same cycle.
    always_comb begin
        grant       = sel;
        grant_valid = sel_ok;
        if (mode) begin
            grant       = rr_grant;
            grant_valid = |in_valid;
        end
    end

    // Pointer only advances on a round-robin transfer; select mode leaves it alone.
    always_comb begin
        ptr_d = ptr_q;
        if (mode && xfer) begin
            ptr_d = grant;
        end
    end

    // Pointer register; resets to N-1 so channel 0 wins the first round-robin grant.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= SW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    logic unused_mode;

    assign unused_mode = mode;

    // Select-only build: the granted channel is always sel.
    always_comb begin
        grant       = sel;
        grant_valid = sel_ok;
    end
`endif

    // Pick granted channel data/valid with a bounded loop so an out-of-range sel never indexes past N.
    always_comb begin
        grant_data     = '0;
        grant_in_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (grant == SW'(i)) begin
                grant_data     = in_data[i*WIDTH +: WIDTH];
                grant_in_valid = in_valid[i];
            end
        end
    end

    assign load = !out_valid_q || out_ready;
    assign xfer = rst_n && load && grant_valid && grant_in_valid;

    // One-hot ready on the granted channel, held low during reset and while stalled.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n && load && grant_valid && (grant == SW'(i));
        end
    end

    // Output register next state: load a word on transfer, drop valid on an idle load, else hold.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        if (load) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = grant_data;
                out_chan_d = grant;
            end
        end
    end

    // Output register; reset discards any word still held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_mux_nto1_reg.sv
// tb/tb_mux_nto1_reg.sv - scoreboard bench for mux_nto1_reg (N=4 main instance, N=3 range instance)
module tb_mux_nto1_reg;

    logic         clk = 1'b0;
    logic         rst_n;

    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [1:0]   sel;
    logic         mode;
    logic [31:0]  out_data;
    logic         out_valid;
    logic [1:0]   out_chan;
    logic         out_ready;

    logic [95:0]  in_data3;
    logic [2:0]   in_valid3;
    logic [2:0]   in_ready3;
    logic [1:0]   sel3;
    logic [31:0]  out_data3;
    logic         out_valid3;
    logic [1:0]   out_chan3;
    logic         out_ready3;

    int n_cmp = 0;
    int n_err = 0;

    logic [33:0] sb[$];
    logic [33:0] sb_e;

    always #5 clk = ~clk;

    mux_nto1_reg #(.WIDTH(32), .N(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .mode(mode), .out_data(out_data),
        .out_valid(out_valid), .out_chan(out_chan), .out_ready(out_ready)
    );

    mux_nto1_reg #(.WIDTH(32), .N(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
        .in_ready(in_ready3), .sel(sel3), .mode(1'b0), .out_data(out_data3),
        .out_valid(out_valid3), .out_chan(out_chan3), .out_ready(out_ready3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive channel ch of the N=4 instance and queue the word the bench expects to come out.
    task automatic push_ch(input int ch, input logic [31:0] d);
        in_data[ch*32 +: 32] = d;
        sb.push_back({2'(ch), d});
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                sb_e = sb.pop_front();
                chk("sb_word", {30'd0, out_chan, out_data}, {30'd0, sb_e});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int          e;

        rst_n = 1'b0; in_data = '0; in_valid = 4'hF; sel = 2'd1; mode = 1'b0; out_ready = 1'b1;
        in_data3 = '0; in_valid3 = 3'b111; sel3 = 2'd0; out_ready3 = 1'b1;
        cyc(); cyc();
        // Reset state, ready held low during reset even with valid inputs.
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_chan", 64'(out_chan), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd0);
        chk("rst_ready3", 64'(in_ready3), 64'd0);
        rst_n = 1'b1; in_valid = 4'h0;

        // Basic select transfer on channel 2.
        cyc();
        sel = 2'd2; in_valid = 4'b0100; push_ch(2, 32'hDEAD_BEEF);
        #1 chk("sel2_ready", 64'(in_ready), 64'b0100);
        cyc();
        in_valid = 4'b0000;
        #1;
        chk("sel2_valid", 64'(out_valid), 64'd1);
        chk("sel2_data", 64'(out_data), 64'hDEAD_BEEF);
        chk("sel2_chan", 64'(out_chan), 64'd2);
        cyc();
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_hold_data", 64'(out_data), 64'hDEAD_BEEF);

        // Ready on the selected channel does not depend on its valid.
        sel = 2'd0;
        #1 chk("ready_no_valid", 64'(in_ready), 64'b0001);

        // Backpressure: hold 1111_1111 for 3 stalled cycles while ch1 waits.
        cyc();
        sel = 2'd0; in_valid = 4'b0001; push_ch(0, 32'h1111_1111);
        cyc();
        out_ready = 1'b0; sel = 2'd1; in_valid = 4'b0010; in_data[63:32] = 32'h2222_2222;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_data", 64'(out_data), 64'h1111_1111);
            cyc();
        end
        out_ready = 1'b1; push_ch(1, 32'h2222_2222);
        #1 chk("bp_release_ready", 64'(in_ready), 64'b0010);
        cyc();
        in_valid = 4'b0000;
        #1 chk("bp_next_data", 64'(out_data), 64'h2222_2222);

        // Back-to-back select transfers, one word per cycle.
        for (int k = 0; k < 8; k++) begin
            cyc();
            in_valid = 4'hF;
            in_data = {$urandom, $urandom, $urandom, $urandom};
            sel = 2'(k % 4);
            sb.push_back({sel, in_data[(k % 4)*32 +: 32]});
            #1 chk("tp_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
        end
        cyc();
        in_valid = 4'h0;
        cyc();

`ifndef MUX_NTO1_REG_RR_EN
        // Without round-robin, mode=1 still behaves as select mode.
        mode = 1'b1; sel = 2'd3; in_valid = 4'hF; push_ch(3, 32'hCAFE_0003);
        #1 chk("mode_ignored_ready", 64'(in_ready), 64'b1000);
        cyc();
        mode = 1'b0; in_valid = 4'h0;
        cyc();
`else
        // Round-robin from reset with all channels valid: 0,1,2,3,0,1,2,3.
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1; mode = 1'b1; in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            e = k % 4;
            d = $urandom;
            push_ch(e, d);
            #1 chk("rr_all_ready", 64'(in_ready), 64'(4'b0001 << e));
            cyc();
        end
        // Alternating 1,3 with ch0/ch2 never ready.
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 0) ? 1 : 3;
            d = $urandom;
            push_ch(e, d);
            #1 chk("rr_1010_ready", 64'(in_ready), 64'(4'b0001 << e));
            cyc();
        end
        in_valid = 4'h0; mode = 1'b0;
        cyc();
`endif

        // Reset while a word is stalled: word dropped, next grant is channel 0.
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1; push_ch(2, 32'h5A5A_5A5A);
        cyc();
        out_ready = 1'b0; in_valid = 4'h0;
        #1 chk("pre_rst_valid", 64'(out_valid), 64'd1);
        cyc();
        rst_n = 1'b0;
        sb.delete();
        cyc();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_chan", 64'(out_chan), 64'd0);
        rst_n = 1'b1; out_ready = 1'b1; sel = 2'd0; in_valid = 4'hF;
`ifdef MUX_NTO1_REG_RR_EN
        mode = 1'b1;
`endif
        push_ch(0, 32'h0BAD_F00D);
        #1 chk("post_rst_ready", 64'(in_ready), 64'b0001);
        cyc();
        in_valid = 4'h0; mode = 1'b0;

        // N=3: out-of-range select grants nothing and valid falls.
        sel3 = 2'd0; in_valid3 = 3'b111; in_data3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        cyc();
        chk("n3_load_valid", 64'(out_valid3), 64'd1);
        chk("n3_load_data", 64'(out_data3), 64'h3333_0000);
        sel3 = 2'd3;
        #1 chk("n3_oor_ready", 64'(in_ready3), 64'd0);
        cyc();
        chk("n3_oor_valid", 64'(out_valid3), 64'd0);
        chk("n3_oor_hold", 64'(out_data3), 64'h3333_0000);

        cyc(); cyc();
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
